s_axil_mcl_fifo_adapter: RTL and testbench

Native-RTL AXI-Lite slave that bridges the host OCL port to the manycore link (MCL) with no vendor IP. Host 32-bit writes are packed into `mcl_width_p`-bit packets and queued in a parametrised TX FIFO. Incoming MCL packets are queued in an RX FIFO and unpacked into 32-bit host reads. Occupancy registers, error responses and a resync control are added so the host can flow-control without polling blindly.

---
 rtl/s_axil_mcl_fifo_adapter.sv | 223 ++++++++++++++++++++++
 tb/tb_s_axil_mcl_fifo_adapter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_axil_mcl_fifo_adapter.sv
// AXI-Lite slave bridging host 32-bit accesses to the manycore link: host writes pack
// into MCL packets through a TX FIFO, received MCL packets unpack into host reads via an RX FIFO.
module s_axil_mcl_fifo_adapter #(
  parameter int mcl_width_p = 80,
  parameter int tx_depth_p  = 16,
  parameter int rx_depth_p  = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [110:0]           s_axil_bus_i,
  output logic [40:0]            s_axil_bus_o,
  output logic                   mcl_v_o,
  output logic [mcl_width_p-1:0] mcl_data_o,
  input  logic                   mcl_r_i,
  input  logic                   mcl_v_i,
  input  logic [mcl_width_p-1:0] mcl_data_i,
  output logic                   mcl_r_o
);

  localparam int unsigned words_lp   = (mcl_width_p + 31) / 32;
  localparam int unsigned stage_w_lp = words_lp * 32;
  localparam int unsigned idx_w_lp   = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam int unsigned tx_ptr_w_lp = $clog2(tx_depth_p);
  localparam int unsigned tx_cnt_w_lp = $clog2(tx_depth_p + 1);
  localparam int unsigned rx_ptr_w_lp = $clog2(rx_depth_p);
  localparam int unsigned rx_cnt_w_lp = $clog2(rx_depth_p + 1);

  typedef enum logic [1:0] {
    resp_okay   = 2'b00,
    resp_slverr = 2'b10,
    resp_decerr = 2'b11
  } resp_e;

  // Request bus, MSB first: awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
  // araddr, arprot, arvalid, rready.
  logic [31:0] awaddr, wdata, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        unused_bus;

  assign awaddr  = s_axil_bus_i[110:79];
  assign awvalid = s_axil_bus_i[75];
  assign wdata   = s_axil_bus_i[74:43];
  assign wvalid  = s_axil_bus_i[38];
  assign bready  = s_axil_bus_i[37];
  assign araddr  = s_axil_bus_i[36:5];
  assign arvalid = s_axil_bus_i[1];
  assign rready  = s_axil_bus_i[0];
  assign unused_bus = ^{awaddr[31:8], s_axil_bus_i[78:76], s_axil_bus_i[42:39],
                        araddr[31:8], s_axil_bus_i[4:2]};

  logic                  aw_held, w_held;
  logic [7:0]            aw_addr_r;
  logic [31:0]           w_data_r;
  logic                  bvalid_r, rvalid_r;
  resp_e                 bresp_r, rresp_r;
  logic [31:0]           rdata_r;
  logic [idx_w_lp-1:0]   tx_idx, rx_idx;
  logic [stage_w_lp-1:0] staging, stage_next;

  logic [mcl_width_p-1:0] tx_mem [tx_depth_p];
  logic [tx_ptr_w_lp-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [tx_cnt_w_lp-1:0] tx_count;
  logic [mcl_width_p-1:0] rx_mem [rx_depth_p];
  logic [rx_ptr_w_lp-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [rx_cnt_w_lp-1:0] rx_count;

  logic aw_fire, w_fire, commit, b_done, ar_fire, r_done;
  logic wr_tx, tx_last, tx_full, tx_push, tx_pop, resync;
  logic rd_rx, rx_empty, rx_last, rx_adv, rx_pop, rx_push;
  logic [stage_w_lp-1:0] rx_head;
  logic [31:0]           rx_word, r_data_next;
  resp_e                 b_resp_next, r_resp_next;

  assign aw_fire = awvalid & ~aw_held;
  assign w_fire  = wvalid & ~w_held;
  assign commit  = aw_held & w_held & ~bvalid_r;
  assign b_done  = bvalid_r & bready;
  assign ar_fire = arvalid & ~rvalid_r;
  assign r_done  = rvalid_r & rready;

  assign wr_tx   = commit & (aw_addr_r == 8'h00);
  assign tx_last = (tx_idx == idx_w_lp'(words_lp - 1));
  assign tx_full = (tx_count == tx_cnt_w_lp'(tx_depth_p));
  assign tx_push = wr_tx & tx_last & ~tx_full;
  assign tx_pop  = mcl_v_o & mcl_r_i;
  assign resync  = commit & (aw_addr_r == 8'h10) & w_data_r[0];

  assign rd_rx    = ar_fire & (araddr[7:0] == 8'h0C);
  assign rx_empty = (rx_count == '0);
  assign rx_last  = (rx_idx == idx_w_lp'(words_lp - 1));
  assign rx_adv   = rd_rx & ~rx_empty;
  assign rx_pop   = rx_adv & rx_last;
  assign rx_push  = mcl_v_i & mcl_r_o;

  assign mcl_v_o    = (tx_count != '0);
  assign mcl_data_o = mcl_v_o ? tx_mem[tx_rd_ptr] : '0;
  assign mcl_r_o    = (rx_count != rx_cnt_w_lp'(rx_depth_p));

  assign s_axil_bus_o = {~aw_held, ~w_held, bresp_r, bvalid_r,
                         ~rvalid_r, rdata_r, rresp_r, rvalid_r};

  always_comb begin
    stage_next = staging;
    for (int unsigned k = 0; k < words_lp; k++)
      if (tx_idx == idx_w_lp'(k)) stage_next[32*k +: 32] = w_data_r;
  end

  // Zero-extend the head so bits above the packet width read back as 0.
  always_comb begin
    rx_head = '0;
    rx_head[mcl_width_p-1:0] = rx_mem[rx_rd_ptr];
    rx_word = '0;
    for (int unsigned k = 0; k < words_lp; k++)
      if (rx_idx == idx_w_lp'(k)) rx_word = rx_head[32*k +: 32];
  end

  always_comb begin
    b_resp_next = resp_okay;
    case (aw_addr_r)
      8'h00:                      b_resp_next = (tx_last && tx_full) ? resp_slverr : resp_okay;
      8'h04, 8'h08, 8'h0C, 8'h10: b_resp_next = resp_okay;
      default:                    b_resp_next = resp_decerr;
    endcase
  end

  always_comb begin
    r_data_next = '0;
    r_resp_next = resp_okay;
    case (araddr[7:0])
      8'h00: r_data_next = '0;
      8'h04: r_data_next = 32'(tx_depth_p) - 32'(tx_count);
      8'h08: r_data_next = 32'(rx_count);
      8'h0C: begin
        if (rx_empty) r_resp_next = resp_slverr;
        else          r_data_next = rx_word;
      end
      8'h10: r_data_next = {16'(tx_idx), 16'(rx_idx)};
      default: r_resp_next = resp_decerr;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_r <= '0;
      w_data_r  <= '0;
      bvalid_r  <= 1'b0;
      bresp_r   <= resp_okay;
      rvalid_r  <= 1'b0;
      rresp_r   <= resp_okay;
      rdata_r   <= '0;
      tx_idx    <= '0;
      rx_idx    <= '0;
      staging   <= '0;
    end else begin
      if (b_done) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_r <= awaddr[7:0];
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_r <= wdata;
      end

      if (commit) begin
        bvalid_r <= 1'b1;
        bresp_r  <= b_resp_next;
      end else if (b_done) begin
        bvalid_r <= 1'b0;
      end

      if (ar_fire) begin
        rvalid_r <= 1'b1;
        rdata_r  <= r_data_next;
        rresp_r  <= r_resp_next;
      end else if (r_done) begin
        rvalid_r <= 1'b0;
      end

      if (wr_tx) begin
        staging <= stage_next;
        tx_idx  <= tx_last ? '0 : tx_idx + idx_w_lp'(1);
      end
      if (rx_adv) rx_idx <= rx_last ? '0 : rx_idx + idx_w_lp'(1);

      // Resync overrides a same-cycle RX index advance; a pop already in flight still lands.
      if (resync) begin
        staging <= '0;
        tx_idx  <= '0;
        rx_idx  <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + tx_ptr_w_lp'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + tx_ptr_w_lp'(1);
      tx_count <= tx_count + tx_cnt_w_lp'(tx_push) - tx_cnt_w_lp'(tx_pop);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + rx_ptr_w_lp'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + rx_ptr_w_lp'(1);
      rx_count <= rx_count + rx_cnt_w_lp'(rx_push) - rx_cnt_w_lp'(rx_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= stage_next[mcl_width_p-1:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= mcl_data_i;
  end

endmodule

// File: tb/tb_s_axil_mcl_fifo_adapter.sv
// Bench for s_axil_mcl_fifo_adapter: directed and randomized traffic checked against
// a queue-based model of the host-visible packing, unpacking and occupancy rules.
module tb_s_axil_mcl_fifo_adapter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] awaddr, wdata, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [110:0] bus_i;
  logic [40:0]  bus_o;
  logic        mcl_v_o, mcl_r_i, mcl_v_i, mcl_r_o;
  logic [79:0] mcl_data_o, mcl_data_i;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int passed = 0;

  logic [31:0] m_stage [3];
  int          m_tx_idx;
  int          m_rx_idx;
  logic [79:0] m_tx_q [$];
  logic [79:0] m_rx_q [$];

  assign bus_i = {awaddr, 3'b000, awvalid, wdata, 4'hF, wvalid, bready,
                  araddr, 3'b000, arvalid, rready};
  assign awready = bus_o[40];
  assign wready  = bus_o[39];
  assign bresp   = bus_o[38:37];
  assign bvalid  = bus_o[36];
  assign arready = bus_o[35];
  assign rdata   = bus_o[34:3];
  assign rresp   = bus_o[2:1];
  assign rvalid  = bus_o[0];

  s_axil_mcl_fifo_adapter #(.mcl_width_p(80), .tx_depth_p(16), .rx_depth_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .s_axil_bus_i(bus_i), .s_axil_bus_o(bus_o),
    .mcl_v_o(mcl_v_o), .mcl_data_o(mcl_data_o), .mcl_r_i(mcl_r_i),
    .mcl_v_i(mcl_v_i), .mcl_data_i(mcl_data_i), .mcl_r_o(mcl_r_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] model_tx_write(input logic [31:0] d);
    logic [95:0] pkt;
    m_stage[m_tx_idx] = d;
    if (m_tx_idx < 2) begin
      m_tx_idx++;
      return 2'b00;
    end
    m_tx_idx = 0;
    if (m_tx_q.size() >= 16) return 2'b10;
    pkt = {m_stage[2], m_stage[1], m_stage[0]};
    m_tx_q.push_back(pkt[79:0]);
    return 2'b00;
  endfunction

  function automatic void model_rx_read(output logic [31:0] d, output logic [1:0] r);
    logic [95:0] w;
    if (m_rx_q.size() == 0) begin
      d = 32'h0;
      r = 2'b10;
      return;
    end
    w = {16'h0, m_rx_q[0]};
    d = w[32*m_rx_idx +: 32];
    r = 2'b00;
    m_rx_idx++;
    if (m_rx_idx == 3) begin
      m_rx_idx = 0;
      void'(m_rx_q.pop_front());
    end
  endfunction

  function automatic void model_resync();
    m_tx_idx = 0;
    m_rx_idx = 0;
    for (int i = 0; i < 3; i++) m_stage[i] = 32'h0;
  endfunction

  function automatic logic [79:0] rand_pkt();
    return {16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // ---------------- bus drivers ----------------
  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    bit aw_ok, w_ok;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wvalid = 1'b1; bready = 1'b1;
    aw_ok = 0; w_ok = 0;
    for (int n = 0; n < 50 && !(aw_ok && w_ok); n++) begin
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      @(negedge clk);
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_ok && w_ok)) begin
      bready = 1'b0;
      return;
    end
    for (int n = 0; n < 50; n++) begin
      if (bvalid) begin
        resp = bresp;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs;
    data = 32'hxxxxxxxx;
    resp = 2'bxx;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    hs = 0;
    for (int n = 0; n < 50; n++) begin
      if (arready) hs = 1;
      @(negedge clk);
      if (hs) break;
    end
    arvalid = 1'b0;
    if (!hs) begin
      rready = 1'b0;
      return;
    end
    for (int n = 0; n < 50; n++) begin
      if (rvalid) begin
        data = rdata;
        resp = rresp;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic mcl_push(input logic [79:0] d);
    bit acc;
    acc = 0;
    @(negedge clk);
    mcl_v_i = 1'b1; mcl_data_i = d;
    for (int n = 0; n < 50; n++) begin
      if (mcl_r_o) acc = 1;
      @(negedge clk);
      if (acc) break;
    end
    mcl_v_i = 1'b0;
    if (acc) m_rx_q.push_back(d);
    checks++;
    if (!acc) $display("FAIL mcl_push: mcl_r_o never high, got accepted=0 expected 1");
    else passed++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    mcl_r_i = 0; mcl_v_i = 0; mcl_data_i = '0;
    m_tx_idx = 0; m_rx_idx = 0;
    for (int i = 0; i < 3; i++) m_stage[i] = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b111_00_0000)
      $display("FAIL reset_axil: got rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b expected 111 0 0 00 00",
               awready, wready, arready, bvalid, rvalid, bresp, rresp);
    else passed++;
    checks++;
    if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata);
    else passed++;
    checks++;
    if ({mcl_v_o, mcl_r_o} !== 2'b01 || mcl_data_o !== 80'h0)
      $display("FAIL reset_mcl: got v_o=%b r_o=%b data=%h expected 0 1 0", mcl_v_o, mcl_r_o, mcl_data_o);
    else passed++;
    reset_n = 1'b1;
    // Leave a W hold and a pending R response in flight, then reset mid-cycle.
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; araddr = 32'h08; arvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if ({wready, rvalid} !== 2'b01) $display("FAIL pre_reset_hold: got wready=%b rvalid=%b expected 0 1", wready, rvalid);
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({wready, rvalid, bvalid} !== 3'b100)
      $display("FAIL async_reset: got wready=%b rvalid=%b bvalid=%b expected 1 0 0", wready, rvalid, bvalid);
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid} !== 3'b110)
      $display("FAIL post_reset: got awready=%b wready=%b bvalid=%b expected 1 1 0", awready, wready, bvalid);
    else passed++;
  endtask

  task automatic test_tx_pack();
    logic [31:0] words [3];
    logic [1:0] r, er;
    logic [31:0] d;
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h00003333;
    mcl_r_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      axil_write(32'h00, words[i], r);
      er = model_tx_write(words[i]);
      checks++;
      if (r !== er) $display("FAIL tx_pack_resp%0d: got %b expected %b", i, r, er);
      else passed++;
    end
    checks++;
    if (mcl_v_o !== 1'b1 || mcl_data_o !== 80'h3333_22222222_11111111)
      $display("FAIL tx_pack_packet: got v=%b data=%h expected 1 3333_22222222_11111111", mcl_v_o, mcl_data_o);
    else passed++;
    axil_read(32'h04, d, r);
    checks++;
    if (d !== 32'd15 || r !== 2'b00) $display("FAIL tx_vacancy_one: got %0d resp %b expected 15 resp 00", d, r);
    else passed++;
  endtask

  task automatic test_tx_drain();
    int got, exp_n;
    logic [79:0] e;
    got = 0;
    exp_n = m_tx_q.size();
    @(negedge clk);
    mcl_r_i = 1'b1;
    for (int i = 0; i < exp_n + 8; i++) begin
      if (mcl_v_o) begin
        checks++;
        if (m_tx_q.size() == 0) $display("FAIL tx_extra_packet: got data=%h expected no packet", mcl_data_o);
        else begin
          e = m_tx_q.pop_front();
          if (mcl_data_o !== e) $display("FAIL tx_pop%0d: got %h expected %h", got, mcl_data_o, e);
          else passed++;
        end
        got++;
      end
      @(negedge clk);
    end
    mcl_r_i = 1'b0;
    checks++;
    if (got !== exp_n || mcl_v_o !== 1'b0)
      $display("FAIL tx_drain_count: got %0d pops v=%b expected %0d pops v=0", got, mcl_v_o, exp_n);
    else passed++;
  endtask

  task automatic test_tx_full();
    logic [1:0] r, er;
    logic [31:0] d, wd;
    for (int i = 0; i < 15 * 3 + 3; i++) begin
      wd = $urandom;
      axil_write(32'h00, wd, r);
      er = model_tx_write(wd);
      checks++;
      if (r !== er) $display("FAIL tx_fill_resp%0d: got %b expected %b", i, r, er);
      else passed++;
    end
    axil_read(32'h10, d, r);
    checks++;
    if (d !== {16'(m_tx_idx), 16'(m_rx_idx)}) $display("FAIL tx_full_idx: got %h expected %h", d, {16'(m_tx_idx), 16'(m_rx_idx)});
    else passed++;
    axil_read(32'h04, d, r);
    checks++;
    if (d !== 32'(16 - m_tx_q.size())) $display("FAIL tx_vacancy_full: got %0d expected %0d", d, 16 - m_tx_q.size());
    else passed++;
    test_tx_drain();
  endtask

  task automatic test_rx_unpack();
    logic [1:0] r, er;
    logic [31:0] d, ed;
    mcl_push(80'hABCD_01234567_89ABCDEF);
    axil_read(32'h08, d, r);
    checks++;
    if (d !== 32'd1) $display("FAIL rx_occ_one: got %0d expected 1", d);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      axil_read(32'h0C, d, r);
      model_rx_read(ed, er);
      checks++;
      if (d !== ed || r !== er) $display("FAIL rx_unpack%0d: got %h/%b expected %h/%b", i, d, r, ed, er);
      else passed++;
      if (i == 2) begin
        axil_read(32'h08, d, r);
        checks++;
        if (d !== 32'd0) $display("FAIL rx_occ_zero: got %0d expected 0", d);
        else passed++;
      end
    end
  endtask

  task automatic test_rx_fill();
    int accepted;
    logic [1:0] r, er;
    logic [31:0] d, ed;
    accepted = 0;
    @(negedge clk);
    mcl_v_i = 1'b1;
    mcl_data_i = rand_pkt();
    for (int i = 0; i < 40; i++) begin
      if (mcl_r_o) begin
        m_rx_q.push_back(mcl_data_i);
        accepted++;
        @(negedge clk);
        mcl_data_i = rand_pkt();
      end else @(negedge clk);
    end
    mcl_v_i = 1'b0;
    checks++;
    if (accepted !== 16 || mcl_r_o !== 1'b0)
      $display("FAIL rx_fill: got accepted=%0d r_o=%b expected 16 0", accepted, mcl_r_o);
    else passed++;
    axil_read(32'h08, d, r);
    checks++;
    if (d !== 32'd16) $display("FAIL rx_occ_full: got %0d expected 16", d);
    else passed++;
    for (int i = 0; i < 48; i++) begin
      axil_read(32'h0C, d, r);
      model_rx_read(ed, er);
      checks++;
      if (d !== ed || r !== er) $display("FAIL rx_drain%0d: got %h/%b expected %h/%b", i, d, r, ed, er);
      else passed++;
      if (i == 2) begin
        checks++;
        if (mcl_r_o !== 1'b1) $display("FAIL rx_reraise: got r_o=%b expected 1", mcl_r_o);
        else passed++;
      end
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] wd, d;
    logic [1:0] r, er;
    int high;
    wd = $urandom;
    @(negedge clk);
    bready = 1'b0; wvalid = 1'b1; wdata = wd; awaddr = 32'h00;
    @(negedge clk);
    wvalid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wready, awready, bvalid} !== 3'b010)
      $display("FAIL w_first_hold: got wready=%b awready=%b bvalid=%b expected 0 1 0", wready, awready, bvalid);
    else passed++;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    high = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bvalid && !awready && !wready) high++;
    end
    checks++;
    if (high !== 5) $display("FAIL b_hold: got %0d held cycles expected 5", high);
    else passed++;
    er = model_tx_write(wd);
    checks++;
    if (bresp !== er) $display("FAIL w_first_resp: got %b expected %b", bresp, er);
    else passed++;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011)
      $display("FAIL b_release: got bvalid=%b awready=%b wready=%b expected 0 1 1", bvalid, awready, wready);
    else passed++;
    axil_read(32'h10, d, r);
    checks++;
    if (d !== {16'(m_tx_idx), 16'(m_rx_idx)}) $display("FAIL single_commit: got %h expected %h", d, {16'(m_tx_idx), 16'(m_rx_idx)});
    else passed++;
  endtask

  task automatic test_resync();
    logic [31:0] d, ed;
    logic [1:0] r, er;
    mcl_push(rand_pkt());
    axil_read(32'h0C, d, r);
    model_rx_read(ed, er);
    checks++;
    if (d !== ed || r !== er) $display("FAIL resync_pre_word: got %h/%b expected %h/%b", d, r, ed, er);
    else passed++;
    axil_read(32'h10, d, r);
    checks++;
    if (d !== 32'h0001_0001) $display("FAIL resync_pre_idx: got %h expected 00010001", d);
    else passed++;
    axil_write(32'h10, 32'h1, r);
    model_resync();
    checks++;
    if (r !== 2'b00) $display("FAIL resync_resp: got %b expected 00", r);
    else passed++;
    axil_read(32'h10, d, r);
    checks++;
    if (d !== 32'h0) $display("FAIL resync_idx: got %h expected 0", d);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      axil_read(32'h0C, d, r);
      model_rx_read(ed, er);
      checks++;
      if (d !== ed || r !== er) $display("FAIL resync_word%0d: got %h/%b expected %h/%b", i, d, r, ed, er);
      else passed++;
    end
    axil_read(32'h20, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b11) $display("FAIL decerr_read: got %h/%b expected 0/11", d, r);
    else passed++;
    axil_write(32'h20, 32'h1234, r);
    checks++;
    if (r !== 2'b11) $display("FAIL decerr_write: got %b expected 11", r);
    else passed++;
  endtask

  task automatic test_random_mix();
    logic [31:0] d, ed, wd;
    logic [1:0] r, er;
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          wd = $urandom;
          axil_write(32'h00 | ($urandom & 32'hFFFF_FF00), wd, r);
          er = model_tx_write(wd);
          checks++;
          if (r !== er) $display("FAIL mix_tx%0d: got %b expected %b", i, r, er);
          else passed++;
        end
        2: if (m_rx_q.size() < 16) mcl_push(rand_pkt());
        3: begin
          axil_read(32'h0C, d, r);
          model_rx_read(ed, er);
          checks++;
          if (d !== ed || r !== er) $display("FAIL mix_rx%0d: got %h/%b expected %h/%b", i, d, r, ed, er);
          else passed++;
        end
        4: begin
          axil_read(32'h04, d, r);
          checks++;
          if (d !== 32'(16 - m_tx_q.size())) $display("FAIL mix_vac%0d: got %0d expected %0d", i, d, 16 - m_tx_q.size());
          else passed++;
        end
        default: begin
          axil_read(32'h08, d, r);
          checks++;
          if (d !== 32'(m_rx_q.size())) $display("FAIL mix_occ%0d: got %0d expected %0d", i, d, m_rx_q.size());
          else passed++;
          axil_read(32'h10, d, r);
          checks++;
          if (d !== {16'(m_tx_idx), 16'(m_rx_idx)}) $display("FAIL mix_idx%0d: got %h expected %h", i, d, {16'(m_tx_idx), 16'(m_rx_idx)});
          else passed++;
        end
      endcase
    end
    test_tx_drain();
  endtask

  initial begin
    test_reset();
    test_tx_pack();
    test_tx_full();
    test_rx_unpack();
    test_rx_fill();
    test_w_before_aw();
    test_resync();
    test_random_mix();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
